fp16_dot_accumulator: RTL and testbench

//  Consumes the FP16 product stream of the pipelined FP16 multiplier in a systolic-array PE and

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/fp16_add_comb.sv | 97 +++++++++
 rtl/fp16_dot_accumulator.sv | 100 ++++++++++
 tb/tb_fp16_dot_accumulator.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, FSM state encoding and the delay-line tag layout
// used by the dot-product accumulator.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_MAXF = 16'h7BFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Beat tags carried alongside the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/fp16_add_comb.sv
// Combinational IEEE-754 binary16 adder, round-to-nearest-even,
// subnormal inputs and outputs. Finite overflow gives +/-inf unless
// FP16_ACC_SAT_EN is defined, in which case it clamps to +/-65504.
module fp16_add_comb
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic [15:0] big, sml;
  logic [4:0]  eb, es, diff;
  logic [13:0] big_m, al;
  logic [27:0] sh_full;
  logic [14:0] raw;
  logic [3:0]  lz;
  logic        found;
  logic [4:0]  shamt;
  logic [13:0] norm;
  logic [5:0]  exp6, exp_code;
  logic        round_up;
  logic [15:0] rounded;
  logic        ovf;

  assign a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
  assign b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
  assign a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
  assign b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);

  // Align, add/subtract magnitudes, normalise, round, then resolve specials.
  always_comb begin
    big      = (b[14:0] > a[14:0]) ? b : a;
    sml      = (b[14:0] > a[14:0]) ? a : b;
    // Subnormals use an effective exponent of 1 with no hidden bit.
    eb       = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    es       = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    diff     = eb - es;
    big_m    = {(big[14:10] != 5'd0), big[9:0], 3'b000};
    sh_full  = {(sml[14:10] != 5'd0), sml[9:0], 17'd0} >> diff;
    // Far-apart operands collapse entirely into the sticky bit.
    if (diff >= 5'd14) begin
      al = {13'd0, (sml[14:0] != 15'd0)};
    end else begin
      al = {sh_full[27:15], sh_full[14] | (sh_full[13:0] != 14'd0)};
    end
    raw = (a[15] ^ b[15]) ? ({1'b0, big_m} - {1'b0, al})
                          : ({1'b0, big_m} + {1'b0, al});

    lz    = 4'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 4'(13 - i);
        found = 1'b1;
      end
    end

    if (raw[14]) begin
      shamt = 5'd0;
      norm  = {raw[14:2], raw[1] | raw[0]};
      exp6  = {1'b0, eb} + 6'd1;
    end else begin
      // Never normalise below the minimum exponent: the result goes subnormal.
      shamt = ({1'b0, lz} > (eb - 5'd1)) ? (eb - 5'd1) : {1'b0, lz};
      norm  = raw[13:0] << shamt;
      exp6  = {1'b0, eb} - {1'b0, shamt};
    end
    exp_code = norm[13] ? exp6 : 6'd0;

    // Rounding carry ripples into the exponent field, so mantissa overflow
    // and subnormal-to-normal promotion fall out of the same add.
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {exp_code, norm[12:3]} + {15'd0, round_up};
    ovf      = (rounded[15:10] >= 6'd31);

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      sum = FP16_QNAN;
    end else if (a_inf) begin
      sum = {a[15], FP16_PINF[14:0]};
    end else if (b_inf) begin
      sum = {b[15], FP16_PINF[14:0]};
    end else if (raw == 15'd0) begin
      sum = {a[15] & b[15], 15'd0};
    end else if (ovf) begin
`ifdef FP16_ACC_SAT_EN
      sum = {big[15], FP16_MAXF[14:0]};
`else
      sum = {big[15], FP16_PINF[14:0]};
`endif
    end else begin
      sum = {big[15], rounded[14:0]};
    end
  end

endmodule

// File: rtl/fp16_dot_accumulator.sv
// FP16 dot-product accumulator for a systolic PE. Beat tags are delayed to
// line up with the multiplier output, products are summed per vector and one
// registered result per vector is offered on a valid/ready output.
// Optional build macro: FP16_ACC_SAT_EN (saturating overflow in the adder).
//
// Output handshake: out_data/out_terms are held while out_valid=1; the result
// is consumed on a rising edge where out_valid & out_ready. The input stream is
// never stalled: a new result overwrites an unconsumed one and sets err_ovr.
// The FSM state is observable as the internal signal "state".
module fp16_dot_accumulator
  import fp16_pkg::*;
#(
  parameter int MUL_LATENCY = 6,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [15:0]      prod,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_terms,
  output logic             err_ovr
);

  tag_t             dly [MUL_LATENCY];
  tag_t             d;
  state_t           state, state_next;
  logic [15:0]      acc, add_a, acc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             restart, load;

  assign d = dly[MUL_LATENCY-1];

  // Tag delay line matched to the multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= '{valid: in_valid, first: in_first, last: in_last};
      for (int i = 1; i < MUL_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

  // Next state, adder operand selection and term count.
  always_comb begin
    state_next = state;
    restart    = d.valid & (d.first | (state == ST_IDLE));
    load       = d.valid & d.last;
    if (d.valid) state_next = d.last ? ST_IDLE : ST_ACC;
    add_a      = restart ? 16'h0000 : acc;
    if (restart) cnt_next = CNT_W'(1);
    else if (&cnt) cnt_next = cnt;
    else cnt_next = cnt + CNT_W'(1);
  end

  fp16_add_comb u_add (
    .a   (add_a),
    .b   (prod),
    .sum (acc_next)
  );

  // FSM state and running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= 16'h0000;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (d.valid) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end
    end
  end

  // Result register, handshake and sticky overwrite flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_terms <= '0;
      err_ovr   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= acc_next;
        out_terms <= cnt_next;
        if (out_valid && !out_ready) err_ovr <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp16_dot_accumulator.sv
// Bench for fp16_dot_accumulator: products are scheduled MUL_LATENCY cycles
// after their tags (standing in for the multiplier), expected results come from
// a real-arithmetic RNE model and are checked by a monitor via a queue.
module tb_fp16_dot_accumulator;

  localparam int L     = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic [15:0]      prod = 16'h0000;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_terms;
  logic             err_ovr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] sched [0:1023];

  typedef struct {
    logic [15:0]      data;
    logic [CNT_W-1:0] terms;
    int               exp_cyc;
    bit               chk_lat;
    bit               skip;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] vec_q[$];
  exp_t        mon_e;

  fp16_dot_accumulator #(.MUL_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .prod      (prod),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_terms (out_terms),
    .err_ovr   (err_ovr)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * pow2(-24);
    else m = (1024.0 + real'(h[9:0])) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic int rne(real y);
    int  t;
    real f;
    t = $rtoi(y);
    f = y - real'(t);
    if (f > 0.5 || (f == 0.5 && (t % 2) == 1)) t = t + 1;
    return t;
  endfunction

  function automatic logic [15:0] from_real(real x, bit s);
    int e;
    int m;
    if (x < pow2(-14)) begin
      m = rne(x * pow2(24));
      return {s, 15'(m)};
    end
    e = -14;
    while (x >= pow2(e + 1) && e < 40) e++;
    m = rne(x * pow2(10 - e));
    if (m == 2048) begin
      m = 1024;
      e = e + 1;
    end
    if (e > 15) begin
`ifdef FP16_ACC_SAT_EN
      return {s, 15'h7BFF};
`else
      return {s, 15'h7C00};
`endif
    end
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b);
    bit  an, bn, ai, bi;
    real s;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (an || bn) return 16'h7E00;
    if (ai && bi) return (a[15] != b[15]) ? 16'h7E00 : {a[15], 15'h7C00};
    if (ai) return {a[15], 15'h7C00};
    if (bi) return {b[15], 15'h7C00};
    s = to_real(a) + to_real(b);
    if (s == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    if (s < 0.0) return from_real(-s, 1'b1);
    return from_real(s, 1'b0);
  endfunction

  function automatic logic [15:0] rand_fp16();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 65) return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    if (sel < 75) return {1'($urandom), 5'd0, 10'($urandom)};
    if (sel < 80) return {1'($urandom), 5'd30, 10'($urandom)};
    if (sel < 83) return {1'($urandom), 15'h7C00};
    if (sel < 85) return 16'h7E00 | 16'($urandom_range(0, 255));
    return 16'($urandom);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    prod = sched[cyc % 1024];
    sched[cyc % 1024] = 16'($urandom);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_vec(bit chk_lat, bit skip);
    int          n;
    int          last_c;
    logic [15:0] acc;
    exp_t        e;
    n = vec_q.size();
    acc = 16'h0000;
    last_c = 0;
    foreach (vec_q[i]) acc = ref_add(acc, vec_q[i]);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_first = (i == 0);
      in_last  = (i == n - 1);
      sched[(cyc + L) % 1024] = vec_q[i];
      if (i == n - 1) last_c = cyc;
      tick();
    end
    in_valid = 1'b0;
    e.data    = acc;
    e.terms   = CNT_W'((n > 255) ? 255 : n);
    e.exp_cyc = last_c + L + 1;
    e.chk_lat = chk_lat;
    e.skip    = skip;
    exp_q.push_back(e);
    vec_q.delete();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      idle(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      while (exp_q.size() > 0 && exp_q[0].skip) void'(exp_q.pop_front());
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_result: got data=%h terms=%0d at cycle %0d, expected none",
                 out_data, out_terms, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || out_terms !== mon_e.terms ||
            (mon_e.chk_lat && cyc != mon_e.exp_cyc)) begin
          failures = failures + 1;
          $display("FAIL result: got data=%h terms=%0d cycle=%0d, expected data=%h terms=%0d cycle=%0d",
                   out_data, out_terms, cyc, mon_e.data, mon_e.terms,
                   mon_e.chk_lat ? mon_e.exp_cyc : cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ovr_exp;
    for (int i = 0; i < 1024; i++) sched[i] = 16'($urandom);

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_terms", 32'(out_terms), 32'd0);
    chk("rst_err_ovr", 32'(err_ovr), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed vectors
    vec_q = '{16'h3C00, 16'h4000, 16'h3C00, 16'hBC00}; send_vec(1, 0); idle(1);
    vec_q = '{16'h4600}; send_vec(1, 0);
    vec_q = '{16'h4000, 16'h4000}; send_vec(1, 0);
    vec_q = '{16'h7C00, 16'hFC00}; send_vec(1, 0);
    vec_q = '{16'h7BFF, 16'h7BFF}; send_vec(1, 0);
    vec_q = '{16'h0001, 16'h0001}; send_vec(1, 0);
    vec_q = '{16'h3C00, 16'hBC00}; send_vec(1, 0);
    vec_q = '{16'h8000, 16'h8000}; send_vec(1, 0);
    vec_q = '{16'h7E01}; send_vec(1, 0);
    vec_q = '{16'h3C00, 16'h0001}; send_vec(1, 0);
    vec_q = '{16'h03FF, 16'h0001}; send_vec(1, 0);
    vec_q = '{16'h3C00, 16'h9400, 16'h1000}; send_vec(1, 0);
    drain();

    // Term counter saturation
    for (int i = 0; i < 260; i++) vec_q.push_back(16'h3C00);
    send_vec(1, 0);
    drain();

    // Random vectors
    for (int v = 0; v < 60; v++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) vec_q.push_back(rand_fp16());
      send_vec(1, 0);
      idle($urandom_range(0, 2));
    end
    drain();
    idle(3);

    // Overwrite of an unconsumed result
    out_ready = 1'b0;
    vec_q = '{16'h3C00, 16'h3C00}; send_vec(0, 1);
    idle(2);
    ovr_exp = ref_add(ref_add(16'h0000, 16'h4000), 16'h4200);
    vec_q = '{16'h4000, 16'h4200}; send_vec(0, 0);
    idle(L + 3);
    chk("ovr_out_valid", 32'(out_valid), 32'd1);
    chk("ovr_out_data", 32'(out_data), 32'(ovr_exp));
    chk("ovr_err_set", 32'(err_ovr), 32'd1);
    out_ready = 1'b1;
    drain();
    idle(5);
    chk("ovr_err_sticky", 32'(err_ovr), 32'd1);
    chk("ovr_valid_dropped", 32'(out_valid), 32'd0);

    // Reset in the middle of a vector
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_first = (i == 0);
      in_last  = 1'b0;
      sched[(cyc + L) % 1024] = 16'h4800;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_err_ovr", 32'(err_ovr), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    vec_q = '{16'h4400, 16'h3C00}; send_vec(1, 0);
    drain();
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
